// File: rtl/note_sequencer.sv
// note_sequencer: plays a programmable table of note/rest steps into the
// envelope generator's note interface, one outstanding note at a time.
//
// state | meaning
// IDLE  | waiting for start (gated by eg_busy)
// ARM   | latch entry 0 into working registers
// NEXT  | latch entry at step_idx into working registers
// ON    | note_on pulse, pitch presented
// HOLD  | note sounding, hold counter running
// OFF   | note_off pulse
// WAIT  | waiting for eg_done from the envelope generator
// REST  | silent step, hold counter running
module note_sequencer #(
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [6:0]        cfg_pitch,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic              cfg_rest,
  input  logic              cfg_last,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              eg_busy,
  input  logic              eg_done,
  output logic              note_on,
  output logic              note_off,
  output logic [6:0]        pitch,
  output logic [AW-1:0]     step_idx,
  output logic              running,
  output logic              seq_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_NEXT, S_ON, S_HOLD, S_OFF, S_WAIT, S_REST
  } state_t;

  state_t state, state_n;

  logic [6:0]        tbl_pitch [DEPTH];
  logic [HOLD_W-1:0] tbl_hold  [DEPTH];
  logic              tbl_rest  [DEPTH];
  logic              tbl_last  [DEPTH];

  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [AW-1:0]     idx_n;
  logic [6:0]        pitch_n;
  logic              last_q, last_n;
  logic              abort_q, abort_n;
  logic              seq_done_n;
  logic              advance;

  logic [6:0]        rd_pitch;
  logic [HOLD_W-1:0] rd_hold, rd_hold_m1;
  logic              rd_rest, rd_last;
  logic              at_end;

  assign rd_pitch = tbl_pitch[step_idx];
  assign rd_hold  = tbl_hold[step_idx];
  assign rd_rest  = tbl_rest[step_idx];
  assign rd_last  = tbl_last[step_idx];

  // A hold of 0 behaves like 1; the counter holds the remaining cycles minus one.
  assign rd_hold_m1 = (rd_hold == '0) ? '0 : rd_hold - HOLD_W'(1);
  assign at_end     = last_q || (step_idx == AW'(DEPTH - 1));

  assign note_on  = (state == S_ON);
  assign note_off = (state == S_OFF);
  assign running  = (state != S_IDLE);

  // Step table: writable at any time, deliberately not reset.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl_pitch[cfg_addr] <= cfg_pitch;
      tbl_hold[cfg_addr]  <= cfg_hold;
      tbl_rest[cfg_addr]  <= cfg_rest;
      tbl_last[cfg_addr]  <= cfg_last;
    end
  end

  // State and working registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      step_idx <= '0;
      pitch    <= '0;
      last_q   <= 1'b0;
      abort_q  <= 1'b0;
      seq_done <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      step_idx <= idx_n;
      pitch    <= pitch_n;
      last_q   <= last_n;
      abort_q  <= abort_n;
      seq_done <= seq_done_n;
    end
  end

  // Next-state, counter and step-advance decisions.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = step_idx;
    pitch_n    = pitch;
    last_n     = last_q;
    abort_n    = abort_q;
    seq_done_n = 1'b0;
    advance    = 1'b0;

    case (state)
      S_IDLE: begin
        abort_n = 1'b0;
        if (start && !stop && !eg_busy) begin
          state_n = S_ARM;
          idx_n   = '0;
        end
      end
      S_ARM, S_NEXT: begin
        if (stop) begin
          state_n = S_IDLE;
        end else begin
          cnt_n  = rd_hold_m1;
          last_n = rd_last;
          if (rd_rest) begin
            state_n = S_REST;
          end else begin
            state_n = S_ON;
            pitch_n = rd_pitch;
          end
        end
      end
      S_ON: begin
        if (stop) begin
          state_n = S_OFF;
          abort_n = 1'b1;
        end else if (cnt == '0) begin
          state_n = S_OFF;
        end else begin
          cnt_n   = cnt - HOLD_W'(1);
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_n = S_OFF;
          abort_n = 1'b1;
        end else if (cnt == '0) begin
          state_n = S_OFF;
        end else begin
          cnt_n = cnt - HOLD_W'(1);
        end
      end
      S_OFF: begin
        if (stop) abort_n = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (stop) abort_n = 1'b1;
        if (eg_done) begin
          if (abort_q || stop) state_n = S_IDLE;
          else                 advance = 1'b1;
        end
      end
      S_REST: begin
        if (stop) begin
          state_n = S_IDLE;
        end else if (cnt == '0) begin
          advance = 1'b1;
        end else begin
          cnt_n = cnt - HOLD_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Advance is folded into the exit of WAIT/REST; it costs no cycle.
    if (advance) begin
      if (at_end) begin
        if (loop) begin
          idx_n   = '0;
          state_n = S_NEXT;
        end else begin
          seq_done_n = 1'b1;
          state_n    = S_IDLE;
        end
      end else begin
        idx_n   = step_idx + AW'(1);
        state_n = S_NEXT;
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: records output events per cycle and compares
// them against an event list predicted from the step table and timing rules.
module tb_note_sequencer;
  localparam int DEPTH  = 4;
  localparam int HOLD_W = 32;
  localparam int AW     = 2;

  localparam int K_RISE = 1, K_ON = 2, K_OFF = 3, K_DONE = 4, K_FALL = 5;

  logic clk = 1'b0;
  logic rst = 1'b1, cfg_we = 1'b0, cfg_rest = 1'b0, cfg_last = 1'b0;
  logic start = 1'b0, stop = 1'b0, loop_en = 1'b0, eg_busy = 1'b0, eg_done = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [6:0]        cfg_pitch = '0;
  logic [HOLD_W-1:0] cfg_hold = '0;
  logic note_on, note_off, running, seq_done;
  logic [6:0]    pitch;
  logic [AW-1:0] step_idx;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, done_at = -1, sd_count = 0;
  bit rec = 1'b0, prev_run = 1'b0;
  logic [55:0] got_q[$], exp_q[$];
  int dq[$], m_dly[$];
  int m_pitch[DEPTH], m_hold[DEPTH];
  bit m_rest[DEPTH], m_last[DEPTH];

  note_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_pitch(cfg_pitch), .cfg_hold(cfg_hold), .cfg_rest(cfg_rest),
    .cfg_last(cfg_last), .start(start), .stop(stop), .loop(loop_en),
    .eg_busy(eg_busy), .eg_done(eg_done), .note_on(note_on),
    .note_off(note_off), .pitch(pitch), .step_idx(step_idx),
    .running(running), .seq_done(seq_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [55:0] ev(int c, int k, int p, int i);
    return {c, 8'(k), 8'(p), 8'(i)};
  endfunction

  // Monitor: cycle count, event capture, envelope-generator eg_done responder.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    eg_done = (cyc == done_at);
    if (rec) begin
      if (running && !prev_run) got_q.push_back(ev(cyc, K_RISE, 0, 0));
      if (note_on)  got_q.push_back(ev(cyc, K_ON, int'(pitch), int'(step_idx)));
      if (note_off) got_q.push_back(ev(cyc, K_OFF, 0, 0));
      if (seq_done) got_q.push_back(ev(cyc, K_DONE, 0, 0));
      if (!running && prev_run) got_q.push_back(ev(cyc, K_FALL, 0, 0));
    end
    if (note_off) done_at = cyc + ((dq.size() > 0) ? dq.pop_front() : 3);
    if (seq_done) sd_count++;
    if (note_on || note_off) begin
      n_assert++;
      if (note_on && note_off) begin
        n_fail++;
        $display("FAIL pulse_overlap cycle %0d note_on=%b note_off=%b required not both", cyc, note_on, note_off);
      end
    end
    prev_run = running;
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic write_entry(int a, int p, int h, bit r, bit l);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_pitch = 7'(p);
    cfg_hold = HOLD_W'(h); cfg_rest = r; cfg_last = l;
    tick(1);
    cfg_we = 1'b0;
    m_pitch[a] = p; m_hold[a] = h; m_rest[a] = r; m_last[a] = l;
  endtask

  task automatic set_delays(int n, int lo, int hi);
    dq.delete(); m_dly.delete();
    for (int k = 0; k < n; k++) begin
      int d;
      d = $urandom_range(hi, lo);
      dq.push_back(d);
      m_dly.push_back(d);
    end
  endtask

  task automatic prep();
    got_q.delete(); exp_q.delete(); sd_count = 0;
  endtask

  task automatic run_window(int c0, int slen, int stop_at, int busy_until, int end_c);
    while (cyc < end_c) begin
      start = (cyc >= c0) && (cyc < c0 + slen);
      if (stop_at >= 0 && cyc >= stop_at) stop = 1'b1;
      if (cyc == busy_until) eg_busy = 1'b0;
      tick(1);
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Reference: walks the table step by step using the timing rules
  // (note step lasts max(hold,1) then waits for eg_done; rest lasts max(hold,1)).
  function automatic void build_expected(int c, bit lp, int max_steps);
    int b, i, h, r, k;
    bit ending;
    exp_q.push_back(ev(c + 1, K_RISE, 0, 0));
    b = c + 2; i = 0; k = 0;
    for (int s = 0; s < max_steps; s++) begin
      h = (m_hold[i] == 0) ? 1 : m_hold[i];
      if (m_rest[i]) begin
        r = b + h;
      end else begin
        exp_q.push_back(ev(b, K_ON, m_pitch[i], i));
        exp_q.push_back(ev(b + h, K_OFF, 0, 0));
        r = b + h + m_dly[k] + 1;
        k++;
      end
      ending = m_last[i] || (i == DEPTH - 1);
      if (ending && !lp) begin
        exp_q.push_back(ev(r, K_DONE, 0, 0));
        exp_q.push_back(ev(r, K_FALL, 0, 0));
        return;
      end
      i = ending ? 0 : i + 1;
      b = r + 1;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    n_assert += 6;
    if (note_on !== 1'b0)  begin n_fail++; $display("FAIL reset note_on got %b exp 0", note_on); end
    if (note_off !== 1'b0) begin n_fail++; $display("FAIL reset note_off got %b exp 0", note_off); end
    if (pitch !== 7'd0)    begin n_fail++; $display("FAIL reset pitch got %0d exp 0", pitch); end
    if (step_idx !== '0)   begin n_fail++; $display("FAIL reset step_idx got %0d exp 0", step_idx); end
    if (running !== 1'b0)  begin n_fail++; $display("FAIL reset running got %b exp 0", running); end
    if (seq_done !== 1'b0) begin n_fail++; $display("FAIL reset seq_done got %b exp 0", seq_done); end
  endtask

  task automatic test_single_note();
    int c;
    prep();
    write_entry(0, 60, 5, 1'b0, 1'b1);
    set_delays(1, 13, 13);
    c = cyc + 2;
    build_expected(c, 1'b0, 8);
    rec = 1'b1;
    run_window(c, 1, -1, -1, c + 30);
    rec = 1'b0;
    n_assert++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_note events got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[j]) begin
      n_assert++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        n_fail++; $display("FAIL single_note ev%0d got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
      end
    end
  endtask

  task automatic test_three_steps();
    int c;
    prep();
    write_entry(0, 61, 3, 1'b0, 1'b0);
    write_entry(1, 0, 4, 1'b1, 1'b0);
    write_entry(2, 63, 2, 1'b0, 1'b1);
    set_delays(2, 6, 6);
    c = cyc + 2;
    build_expected(c, 1'b0, 8);
    rec = 1'b1;
    run_window(c, 1, -1, -1, c + 40);
    rec = 1'b0;
    n_assert++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL three_steps events got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[j]) begin
      n_assert++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        n_fail++; $display("FAIL three_steps ev%0d got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
      end
    end
  endtask

  task automatic test_hold_boundary();
    int c;
    prep();
    write_entry(0, 50, 0, 1'b0, 1'b0);
    write_entry(1, 51, 1, 1'b0, 1'b1);
    set_delays(2, 2, 2);
    c = cyc + 2;
    build_expected(c, 1'b0, 8);
    rec = 1'b1;
    run_window(c, 1, -1, -1, c + 20);
    rec = 1'b0;
    n_assert++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL hold_boundary events got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[j]) begin
      n_assert++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        n_fail++; $display("FAIL hold_boundary ev%0d got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
      end
    end
  endtask

  task automatic test_random_sequences();
    int c, len;
    bit nolast;
    for (int it = 0; it < 5; it++) begin
      prep();
      len = $urandom_range(4, 1);
      nolast = (len == 4) && ($urandom_range(1, 0) == 1);
      for (int e = 0; e < len; e++)
        write_entry(e, $urandom_range(127, 0), $urandom_range(6, 0),
                    ($urandom_range(2, 0) == 0), (e == len - 1) && !nolast);
      set_delays(4, 1, 5);
      c = cyc + 2;
      build_expected(c, 1'b0, 8);
      rec = 1'b1;
      run_window(c, 1, -1, -1, c + 80);
      rec = 1'b0;
      n_assert++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random%0d events got %0d exp %0d", it, got_q.size(), exp_q.size()); end
      foreach (exp_q[j]) begin
        n_assert++;
        if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
          n_fail++; $display("FAIL random%0d ev%0d got %h exp %h", it, j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_loop_wrap();
    int c, end_c, guard;
    prep();
    write_entry(0, 20, 2, 1'b0, 1'b0);
    write_entry(1, 21, 0, 1'b0, 1'b0);
    write_entry(2, 22, 3, 1'b0, 1'b0);
    write_entry(3, 23, 1, 1'b0, 1'b0);
    set_delays(8, 1, 4);
    loop_en = 1'b1;
    c = cyc + 2;
    build_expected(c, 1'b1, 6);
    end_c = int'(exp_q[exp_q.size() - 1][55:24]);
    rec = 1'b1;
    run_window(c, 1, -1, -1, end_c);
    rec = 1'b0;
    stop = 1'b1;
    guard = 0;
    while (running && guard < 40) begin tick(1); guard++; end
    stop = 1'b0;
    loop_en = 1'b0;
    n_assert += 3;
    if (running !== 1'b0) begin n_fail++; $display("FAIL loop_stop running got %b exp 0", running); end
    if (sd_count != 0) begin n_fail++; $display("FAIL loop_seq_done count got %0d exp 0", sd_count); end
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL loop_wrap events got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[j]) begin
      n_assert++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        n_fail++; $display("FAIL loop_wrap ev%0d got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
      end
    end
  endtask

  task automatic test_abort();
    int c;
    // stop during HOLD: note_off next cycle, IDLE after eg_done
    prep();
    write_entry(0, 40, 8, 1'b0, 1'b1);
    set_delays(1, 4, 4);
    c = cyc + 2;
    exp_q.push_back(ev(c + 1, K_RISE, 0, 0));
    exp_q.push_back(ev(c + 2, K_ON, 40, 0));
    exp_q.push_back(ev(c + 6, K_OFF, 0, 0));
    exp_q.push_back(ev(c + 11, K_FALL, 0, 0));
    rec = 1'b1;
    run_window(c, 1, c + 5, -1, c + 20);
    rec = 1'b0;
    n_assert += 2;
    if (sd_count != 0) begin n_fail++; $display("FAIL abort_hold seq_done count got %0d exp 0", sd_count); end
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abort_hold events got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[j]) begin
      n_assert++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        n_fail++; $display("FAIL abort_hold ev%0d got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
      end
    end
    // stop during REST: IDLE next cycle
    prep();
    write_entry(0, 0, 10, 1'b1, 1'b1);
    c = cyc + 2;
    exp_q.push_back(ev(c + 1, K_RISE, 0, 0));
    exp_q.push_back(ev(c + 5, K_FALL, 0, 0));
    rec = 1'b1;
    run_window(c, 1, c + 4, -1, c + 20);
    rec = 1'b0;
    n_assert += 2;
    if (sd_count != 0) begin n_fail++; $display("FAIL abort_rest seq_done count got %0d exp 0", sd_count); end
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abort_rest events got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[j]) begin
      n_assert++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        n_fail++; $display("FAIL abort_rest ev%0d got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
      end
    end
  endtask

  task automatic test_busy_gate();
    int c;
    prep();
    write_entry(0, 33, 3, 1'b0, 1'b1);
    set_delays(1, 3, 3);
    eg_busy = 1'b1;
    c = cyc + 2;
    build_expected(c + 8, 1'b0, 8);
    rec = 1'b1;
    run_window(c, 9, -1, c + 8, c + 30);
    rec = 1'b0;
    n_assert++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL busy_gate events got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[j]) begin
      n_assert++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        n_fail++; $display("FAIL busy_gate ev%0d got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
      end
    end
  endtask

  task automatic test_reset_mid_note();
    int c;
    prep();
    write_entry(0, 70, 2, 1'b0, 1'b0);
    write_entry(1, 71, 9, 1'b0, 1'b1);
    set_delays(1, 2, 2);
    c = cyc + 2;
    exp_q.push_back(ev(c + 1, K_RISE, 0, 0));
    exp_q.push_back(ev(c + 2, K_ON, 70, 0));
    exp_q.push_back(ev(c + 4, K_OFF, 0, 0));
    exp_q.push_back(ev(c + 8, K_ON, 71, 1));
    exp_q.push_back(ev(c + 11, K_FALL, 0, 0));
    rec = 1'b1;
    run_window(c, 1, -1, -1, c + 10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_assert += 6;
    if (note_on !== 1'b0)  begin n_fail++; $display("FAIL rst_mid note_on got %b exp 0", note_on); end
    if (note_off !== 1'b0) begin n_fail++; $display("FAIL rst_mid note_off got %b exp 0", note_off); end
    if (pitch !== 7'd0)    begin n_fail++; $display("FAIL rst_mid pitch got %0d exp 0", pitch); end
    if (step_idx !== '0)   begin n_fail++; $display("FAIL rst_mid step_idx got %0d exp 0", step_idx); end
    if (running !== 1'b0)  begin n_fail++; $display("FAIL rst_mid running got %b exp 0", running); end
    if (seq_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid seq_done got %b exp 0", seq_done); end
    tick(9);
    rec = 1'b0;
    n_assert++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_mid events got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[j]) begin
      n_assert++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        n_fail++; $display("FAIL rst_mid ev%0d got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
      end
    end
    // replay from entry 0 with the table untouched by reset
    prep();
    set_delays(2, 3, 3);
    c = cyc + 2;
    build_expected(c, 1'b0, 8);
    rec = 1'b1;
    run_window(c, 1, -1, -1, c + 40);
    rec = 1'b0;
    n_assert++;
    if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rst_replay events got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[j]) begin
      n_assert++;
      if (j >= got_q.size() || got_q[j] !== exp_q[j]) begin
        n_fail++; $display("FAIL rst_replay ev%0d got %h exp %h", j, (j < got_q.size()) ? got_q[j] : 56'h0, exp_q[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_three_steps();
    test_hold_boundary();
    test_random_sequences();
    test_loop_wrap();
    test_abort();
    test_busy_gate();
    test_reset_mid_note();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
